pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on misaligned target.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- branch  in  1  decoded conditional branch.
- jump  in  1  decoded JAL.
- jalr  in  1  decoded JALR.
- funct3  in  3  branch condition code.
- zero  in  1  ALU equal flag.
- lt  in  1  ALU signed less-than flag.
- ltu  in  1  ALU unsigned less-than flag.
- imm  in  32  sign-extended immediate.
- alu_result  in  32  JALR target (rs1+imm).
- imem_ready  in  1  instruction word valid this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, for rd write-back.
- instr_valid  out  1  one-cycle commit strobe.
- taken  out  1  control transfer taken (valid with instr_valid).
- trap  out  1  one-cycle misaligned-target pulse.

Function
REQ-005 FSM states SHALL be IDLE, FETCH, EXEC, TRAP.
REQ-006 IDLE -> FETCH unconditionally on the first cycle with reset low.
REQ-007 FETCH: imem_req=1, imem_addr=pc held stable; stay until imem_ready=1, then -> EXEC.
REQ-008 EXEC SHALL last exactly one cycle with instr_valid=1; datapath commits in this cycle.
REQ-009 Branch condition from funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; 010/011 SHALL be not taken.
REQ-010 taken = jump | jalr | (branch & cond), valid only while instr_valid=1, else 0.
REQ-011 Target: jalr -> {alu_result[31:1],1'b0}; jump or taken branch -> pc+imm (32-bit wrap, carry discarded); otherwise pc+4 (wraps 32'hFFFF_FFFC -> 0).
REQ-012 Priority when several decode inputs are high: jalr > jump > branch.
REQ-013 If selected target[1:0] != 2'b00, EXEC SHALL -> TRAP and pc SHALL NOT take the target; otherwise pc <= target, -> FETCH.
REQ-014 TRAP: one cycle, trap=1, pc <= TRAP_VECTOR, -> FETCH.
REQ-015 pc_plus4 SHALL always equal pc+4 combinationally.
REQ-016 imem_ready outside FETCH SHALL be ignored.
REQ-017 Throughput: minimum 2 cycles per instruction (FETCH with immediate ready + EXEC).

Reset
REQ-018 On reset: state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, taken=0, trap=0.
REQ-019 Reset asserted in any state, including mid-FETCH, SHALL override all transitions on that edge; no instr_valid or trap SHALL follow.

Structure
REQ-020 FSM state encoding and branch funct3 codes SHALL live in shared package riscv_pkg.
REQ-021 Branch condition evaluation SHALL be sub-module branch_cond (funct3, zero, lt, ltu -> cond), replacing the standalone AND gating.

Verification
REQ-022 Reset release, imem_ready=1 always -> imem_addr 0x0 first, instr_valid every 2nd cycle, pc 0x0,0x4,0x8.
REQ-023 pc=0x100, branch=1, funct3=000, zero=1, imm=0xFFFF_FFF8 -> taken=1, next imem_addr 0x0F8; zero=0 -> 0x104.
REQ-024 jalr=1, alu_result=0x0000_2003 -> next pc 0x2002 -> trap=1, pc=0x100.
REQ-025 imem_ready held low 5 cycles in FETCH -> imem_req=1, imem_addr constant, no instr_valid.
REQ-026 reset pulsed mid-FETCH at pc=0x40 -> pc=0x0, imem_req=0 next cycle, then refetch 0x0.
REQ-027 funct3=010 with branch=1, zero=1 -> taken=0, pc advances by 4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and
// conditional-branch funct3 codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        TRAP  = 2'd3
    } seq_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond.sv
// Evaluates the conditional-branch outcome from funct3 and the ALU flags.
// The reserved codes 010/011 never take the branch.
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = !zero;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = !lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction, commits it in a
// single EXEC cycle, and redirects to TRAP_VECTOR on a misaligned target.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        jump,
    input  logic        jalr,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        taken,
    output logic        trap
);

    seq_state_t  state;
    logic        cond;
    logic        transfer;
    logic [31:0] target;

    branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .cond   (cond)
    );

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign transfer  = jalr | jump | (branch & cond);
    assign taken     = instr_valid & transfer;

    // jalr wins over jump, which wins over a conditional branch
    always_comb begin
        target = pc_plus4;
        if (jalr) begin
            target = alu_result & 32'hFFFF_FFFE;
        end else if (jump || (branch && cond)) begin
            target = pc + imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            trap        <= 1'b0;
        end else begin
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            trap        <= 1'b0;
            unique case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ready) begin
                        state       <= EXEC;
                        instr_valid <= 1'b1;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                EXEC: begin
                    // a misaligned target is never loaded into pc
                    if (target[1:0] != 2'b00) begin
                        state <= TRAP;
                        trap  <= 1'b1;
                    end else begin
                        pc       <= target;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                TRAP: begin
                    pc       <= TRAP_VECTOR;
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed
// next-PC values for sequential, branch, jump, jalr, trap and reset cases.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  funct3;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        taken;
    logic        trap;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;

    typedef struct packed {
        logic [2:0] f3;
        logic       z;
        logic       l;
        logic       lu;
        logic       tk;
    } bvec_t;

    bvec_t bcc_table [12] = '{
        '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0},
        '{3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
        '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0},
        '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1},
        '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0},
        '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1},
        '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
        '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
        '{3'b110, 1'b0, 1'b1, 1'b0, 1'b0},
        '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
        '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0},
        '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1}
    };

    pc_sequencer #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .branch      (branch),
        .jump        (jump),
        .jalr        (jalr),
        .funct3      (funct3),
        .zero        (zero),
        .lt          (lt),
        .ltu         (ltu),
        .imm         (imm),
        .alu_result  (alu_result),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .taken       (taken),
        .trap        (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic br, input logic jp, input logic jr,
                                 input logic [2:0] f3, input logic z,
                                 input logic l, input logic lu,
                                 input logic [31:0] im, input logic [31:0] alu);
        branch     = br;
        jump       = jp;
        jalr       = jr;
        funct3     = f3;
        zero       = z;
        lt         = l;
        ltu        = lu;
        imm        = im;
        alu_result = alu;
    endtask

    // Starts at a negedge inside FETCH with imem_ready=1, ends at the negedge of the next FETCH
    task automatic runInstr(input string tag, input logic br, input logic jp,
                            input logic jr, input logic [2:0] f3, input logic z,
                            input logic l, input logic lu, input logic [31:0] im,
                            input logic [31:0] alu, input logic exp_taken,
                            input logic [31:0] exp_next, input logic exp_trap);
        checkOutput({tag, " fetch imem_req"}, {31'd0, imem_req}, 32'd1);
        checkOutput({tag, " fetch imem_addr"}, imem_addr, exp_pc);
        checkOutput({tag, " fetch instr_valid"}, {31'd0, instr_valid}, 32'd0);
        stepCycle();
        applyStimulus(br, jp, jr, f3, z, l, lu, im, alu);
        #1;
        checkOutput({tag, " exec instr_valid"}, {31'd0, instr_valid}, 32'd1);
        checkOutput({tag, " exec pc"}, pc, exp_pc);
        checkOutput({tag, " exec pc_plus4"}, pc_plus4, exp_pc + 32'd4);
        checkOutput({tag, " exec taken"}, {31'd0, taken}, {31'd0, exp_taken});
        checkOutput({tag, " exec imem_req"}, {31'd0, imem_req}, 32'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        if (exp_trap) begin
            #1;
            checkOutput({tag, " trap pulse"}, {31'd0, trap}, 32'd1);
            checkOutput({tag, " trap instr_valid"}, {31'd0, instr_valid}, 32'd0);
            checkOutput({tag, " trap taken"}, {31'd0, taken}, 32'd0);
            checkOutput({tag, " trap pc held"}, pc, exp_pc);
            stepCycle();
        end
        checkOutput({tag, " next trap"}, {31'd0, trap}, 32'd0);
        checkOutput({tag, " next pc"}, pc, exp_next);
        checkOutput({tag, " next imem_req"}, {31'd0, imem_req}, 32'd1);
        exp_pc = exp_next;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_pc = 32'h0;
        repeat (3) stepCycle();

        checkOutput("reset pc", pc, 32'h0);
        checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset taken", {31'd0, taken}, 32'd0);
        checkOutput("reset trap", {31'd0, trap}, 32'd0);
        checkOutput("reset pc_plus4", pc_plus4, 32'h4);

        reset = 1'b0;
        stepCycle();

        runInstr("seq0", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4, 0);
        runInstr("seq1", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h8, 0);
        runInstr("seq2", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'hC, 0);

        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput($sformatf("stall%0d imem_req", i), {31'd0, imem_req}, 32'd1);
            checkOutput($sformatf("stall%0d imem_addr", i), imem_addr, 32'hC);
            checkOutput($sformatf("stall%0d instr_valid", i), {31'd0, instr_valid}, 32'd0);
        end
        imem_ready = 1'b1;
        runInstr("after stall", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h10, 0);

        runInstr("jalr misaligned", 0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'h0000_2003,
                 1, 32'h100, 1);
        runInstr("beq taken back", 1, 0, 0, 3'b000, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,
                 1, 32'hF8, 0);
        runInstr("jump fwd", 0, 1, 0, 3'b000, 0, 0, 0, 32'h8, 32'h0, 1, 32'h100, 0);
        runInstr("beq not taken", 1, 0, 0, 3'b000, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,
                 0, 32'h104, 0);
        runInstr("f3 010 reserved", 1, 0, 0, 3'b010, 1, 1, 1, 32'h20, 32'h0,
                 0, 32'h108, 0);

        for (int i = 0; i < 12; i++) begin
            runInstr($sformatf("bcc%0d", i), 1, 0, 0, bcc_table[i].f3, bcc_table[i].z,
                     bcc_table[i].l, bcc_table[i].lu, 32'h20, 32'h0, bcc_table[i].tk,
                     bcc_table[i].tk ? exp_pc + 32'h20 : exp_pc + 32'h4, 0);
        end

        runInstr("prio jalr", 1, 1, 1, 3'b000, 1, 0, 0, 32'h40, 32'h0000_0301,
                 1, 32'h300, 0);
        runInstr("prio jump", 1, 1, 0, 3'b001, 1, 0, 0, 32'h10, 32'h0, 1, 32'h310, 0);
        runInstr("jump misaligned", 0, 1, 0, 3'b000, 0, 0, 0, 32'h2, 32'h0,
                 1, 32'h100, 1);
        runInstr("jalr to top", 0, 0, 1, 3'b000, 0, 0, 0, 32'h0, 32'hFFFF_FFFD,
                 1, 32'hFFFF_FFFC, 0);
        runInstr("wrap", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        runInstr("jump to 40", 0, 1, 0, 3'b000, 0, 0, 0, 32'h40, 32'h0, 1, 32'h40, 0);

        imem_ready = 1'b0;
        stepCycle();
        checkOutput("midfetch imem_addr", imem_addr, 32'h40);
        reset = 1'b1;
        stepCycle();
        checkOutput("midfetch reset pc", pc, 32'h0);
        checkOutput("midfetch reset imem_req", {31'd0, imem_req}, 32'd0);
        checkOutput("midfetch reset instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("midfetch reset trap", {31'd0, trap}, 32'd0);
        reset      = 1'b0;
        imem_ready = 1'b1;
        stepCycle();
        exp_pc = 32'h0;
        runInstr("refetch", 0, 0, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 0, 32'h4, 0);

        stepCycle();
        applyStimulus(0, 1, 0, 3'b000, 0, 0, 0, 32'h1, 32'h0);
        reset = 1'b1;
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        checkOutput("exec reset trap", {31'd0, trap}, 32'd0);
        checkOutput("exec reset pc", pc, 32'h0);
        checkOutput("exec reset instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("exec reset taken", {31'd0, taken}, 32'd0);
        reset = 1'b0;
        stepCycle();
        checkOutput("exec reset refetch req", {31'd0, imem_req}, 32'd1);
        checkOutput("exec reset refetch addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
